// File: rtl/keypad_number_entry.sv
// PS/2 set-2 keypad number entry: accumulates decimal digits into a WIDTH-bit operand
// and commits operand + operator over valid/ready. Optional backspace: KEYPAD_BACKSPACE_EN.
module keypad_number_entry #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_DIGITS = 9,
  localparam int unsigned CW        = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  output logic [WIDTH-1:0] value,
  output logic [CW-1:0]    digit_count,
  output logic             overflow,
  output logic             cmt_valid,
  input  logic             cmt_ready,
  output logic [WIDTH-1:0] cmt_value,
  output logic [3:0]       cmt_op,
  output logic             dropped
);

  typedef enum logic [1:0] {S_ENTRY, S_BREAK, S_HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_value;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_cmt_valid;
  logic [WIDTH-1:0] r_cmt_value;
  logic [3:0]       r_cmt_op;
  logic             r_dropped;

  logic             w_is_digit;
  logic [3:0]       w_digit;
  logic             w_is_op;
  logic [3:0]       w_op;
  logic [WIDTH+3:0] w_ext;
  logic [WIDTH+3:0] w_mul;
  logic             w_lead_zero;
  logic             w_reject;

  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (code_in)
      8'h45: w_digit = 4'd0;
      8'h16: w_digit = 4'd1;
      8'h1E: w_digit = 4'd2;
      8'h26: w_digit = 4'd3;
      8'h25: w_digit = 4'd4;
      8'h2E: w_digit = 4'd5;
      8'h36: w_digit = 4'd6;
      8'h3D: w_digit = 4'd7;
      8'h3E: w_digit = 4'd8;
      8'h46: w_digit = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end

  always_comb begin
    w_is_op = 1'b1;
    w_op    = 4'd0;
    case (code_in)
      8'h15: w_op = 4'd1;
      8'h1D: w_op = 4'd2;
      8'h24: w_op = 4'd3;
      8'h2D: w_op = 4'd4;
      8'h2C: w_op = 4'd5;
      8'h35: w_op = 4'd6;
      8'h3C: w_op = 4'd7;
      8'h43: w_op = 4'd8;
      8'h44: w_op = 4'd9;
      8'h4D: w_op = 4'd10;
      8'h1C: w_op = 4'd11;
      8'h1B: w_op = 4'd12;
      8'h23: w_op = 4'd13;
      8'h5A: w_op = 4'd14;
      default: w_is_op = 1'b0;
    endcase
  end

  // value*10 + d evaluated 4 bits wider so any carry past WIDTH flags overflow
  always_comb begin
    w_ext       = {4'b0000, r_value};
    w_mul       = (w_ext << 3) + (w_ext << 1) + (WIDTH+4)'(w_digit);
    w_lead_zero = (r_cnt == '0) && (r_value == '0) && (w_digit == 4'd0);
    w_reject    = (r_cnt == CW'(MAX_DIGITS)) || (w_mul[WIDTH+3:WIDTH] != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ENTRY;
      r_value     <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_cmt_valid <= 1'b0;
      r_cmt_value <= '0;
      r_cmt_op    <= '0;
      r_dropped   <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      case (r_state)
        S_ENTRY: begin
          if (code_valid) begin
            if (code_in == 8'hF0) begin
              r_state <= S_BREAK;
            end else if (code_in == 8'hE0) begin
              r_state <= S_ENTRY;
            end else if (code_in == 8'h76) begin
              r_value <= '0;
              r_cnt   <= '0;
              r_ovf   <= 1'b0;
`ifdef KEYPAD_BACKSPACE_EN
            end else if (code_in == 8'h66) begin
              if (r_cnt != '0) begin
                r_value <= r_value / WIDTH'(10);
                r_cnt   <= r_cnt - CW'(1);
                r_ovf   <= 1'b0;
              end
`endif
            end else if (w_is_digit) begin
              if (!w_lead_zero) begin
                if (w_reject) begin
                  r_ovf <= 1'b1;
                end else begin
                  r_value <= w_mul[WIDTH-1:0];
                  r_cnt   <= r_cnt + CW'(1);
                end
              end
            end else if (w_is_op) begin
              r_cmt_value <= r_value;
              r_cmt_op    <= w_op;
              r_cmt_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        S_BREAK: begin
          if (code_valid) r_state <= S_ENTRY;
        end
        S_HOLD: begin
          if (code_valid) r_dropped <= 1'b1;
          if (cmt_ready) begin
            r_value     <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_cmt_valid <= 1'b0;
            r_state     <= S_ENTRY;
          end
        end
        default: r_state <= S_ENTRY;
      endcase
    end
  end

  assign value       = r_value;
  assign digit_count = r_cnt;
  assign overflow    = r_ovf;
  assign cmt_valid   = r_cmt_valid;
  assign cmt_value   = r_cmt_value;
  assign cmt_op      = r_cmt_op;
  assign dropped     = r_dropped;

endmodule
